// File: rtl/grad_desc_ctrl.sv
// grad_desc_ctrl: finite-difference gradient descent over four Q8.8 coordinates using an external func unit
module grad_desc_ctrl #(
    parameter int DELTA_LOG2 = 4,
    parameter int LR_SHIFT   = 6,
    parameter int MAX_ITER   = 64,
    parameter int ITER_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       a_init,
    input  logic [15:0]       b_init,
    input  logic [15:0]       c_init,
    input  logic [15:0]       d_init,
    output logic              busy,
    output logic              done,
    output logic [15:0]       a_res,
    output logic [15:0]       b_res,
    output logic [15:0]       c_res,
    output logic [15:0]       d_res,
    output logic [31:0]       z_res,
    output logic [ITER_W-1:0] iter_count,
    output logic              sat_flag,
    output logic              ovf_flag,
    output logic              start_func,
    output logic [15:0]       a_out,
    output logic [15:0]       b_out,
    output logic [15:0]       c_out,
    output logic [15:0]       d_out,
    input  logic [31:0]       z_in,
    input  logic              func_done,
    input  logic              func_ovf
);
    localparam logic signed [16:0] DELTA = 17'(1 << (8 - DELTA_LOG2));
    localparam int SH = LR_SHIFT - DELTA_LOG2;

    typedef enum logic [2:0] {IDLE, REQ, REL, CALC, FINAL_REQ, FINAL_REL, FIN} state_t;

    state_t             state;
    logic signed [15:0] x [4];
    logic signed [31:0] z [5];
    logic [2:0]         eval_idx;
    logic signed [16:0] sum [4];
    logic signed [15:0] pert [4];
    logic signed [32:0] diff [4];
    logic signed [32:0] step [4];
    logic signed [33:0] upd [4];
    logic signed [15:0] x_new [4];
    logic               pert_sat, step_nz, clamp_sat;

    // pert holds the operands of the next perturbed eval (coordinate eval_idx), used on REL -> REQ
    always_comb begin
        pert_sat  = 1'b0;
        step_nz   = 1'b0;
        clamp_sat = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sum[i]    = {x[i][15], x[i]} + DELTA;
            pert[i]   = eval_idx != 3'(i) ? x[i] : sum[i] > 17'sd32767 ? 16'h7fff : sum[i][15:0];
            pert_sat  = pert_sat | (eval_idx == 3'(i) && sum[i] > 17'sd32767);
            diff[i]   = {z[i+1][31], z[i+1]} - {z[0][31], z[0]};
            step[i]   = diff[i] >>> SH;
            step_nz   = step_nz | (step[i] != '0);
            upd[i]    = {{18{x[i][15]}}, x[i]} - {step[i][32], step[i]};
            x_new[i]  = upd[i] > 34'sd32767 ? 16'h7fff : upd[i] < -34'sd32768 ? 16'h8000 : upd[i][15:0];
            clamp_sat = clamp_sat | upd[i] > 34'sd32767 | upd[i] < -34'sd32768;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            for (int i = 0; i < 4; i++) x[i] <= '0;
            for (int i = 0; i < 5; i++) z[i] <= '0;
            eval_idx   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            a_res      <= '0;
            b_res      <= '0;
            c_res      <= '0;
            d_res      <= '0;
            z_res      <= '0;
            iter_count <= '0;
            sat_flag   <= 1'b0;
            ovf_flag   <= 1'b0;
            start_func <= 1'b0;
            a_out      <= '0;
            b_out      <= '0;
            c_out      <= '0;
            d_out      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    x[0]       <= a_init;
                    x[1]       <= b_init;
                    x[2]       <= c_init;
                    x[3]       <= d_init;
                    a_out      <= a_init;
                    b_out      <= b_init;
                    c_out      <= c_init;
                    d_out      <= d_init;
                    iter_count <= '0;
                    sat_flag   <= 1'b0;
                    ovf_flag   <= 1'b0;
                    eval_idx   <= '0;
                    busy       <= 1'b1;
                    start_func <= 1'b1;
                    state      <= REQ;
                end
                REQ: if (func_done) begin
                    z[eval_idx] <= z_in;
                    ovf_flag    <= ovf_flag | func_ovf;
                    start_func  <= 1'b0;
                    state       <= REL;
                end
                REL: if (!func_done) begin
                    if (eval_idx < 3'd4) begin
                        eval_idx   <= eval_idx + 3'd1;
                        a_out      <= pert[0];
                        b_out      <= pert[1];
                        c_out      <= pert[2];
                        d_out      <= pert[3];
                        sat_flag   <= sat_flag | pert_sat;
                        start_func <= 1'b1;
                        state      <= REQ;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    iter_count <= iter_count + ITER_W'(1);
                    if (!step_nz) begin
                        z_res <= z[0];
                        a_res <= x[0];
                        b_res <= x[1];
                        c_res <= x[2];
                        d_res <= x[3];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FIN;
                    end else begin
                        x          <= x_new;
                        a_out      <= x_new[0];
                        b_out      <= x_new[1];
                        c_out      <= x_new[2];
                        d_out      <= x_new[3];
                        sat_flag   <= sat_flag | clamp_sat;
                        eval_idx   <= '0;
                        start_func <= 1'b1;
                        state      <= iter_count + ITER_W'(1) == ITER_W'(MAX_ITER) ? FINAL_REQ : REQ;
                    end
                end
                FINAL_REQ: if (func_done) begin
                    z_res      <= z_in;
                    ovf_flag   <= ovf_flag | func_ovf;
                    start_func <= 1'b0;
                    state      <= FINAL_REL;
                end
                FINAL_REL: if (!func_done) begin
                    a_res <= x[0];
                    b_res <= x[1];
                    c_res <= x[2];
                    d_res <= x[3];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= FIN;
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_grad_desc_ctrl.sv
// tb_grad_desc_ctrl: random runs against a linear func model, scoreboarded against an iteration-level reference
module tb_grad_desc_ctrl;
    localparam int MAXI = 3;
    localparam int DL   = 16;
    localparam int SH   = 2;

    logic        clk = 0, rst = 1, start = 0;
    logic [15:0] a_init = 0, b_init = 0, c_init = 0, d_init = 0;
    logic        busy, done, sat_flag, ovf_flag, start_func;
    logic [15:0] a_res, b_res, c_res, d_res, a_out, b_out, c_out, d_out;
    logic [31:0] z_res;
    logic [7:0]  iter_count;
    logic [31:0] z_in = 0;
    logic        func_done = 0, func_ovf = 0;

    grad_desc_ctrl #(.DELTA_LOG2(4), .LR_SHIFT(6), .MAX_ITER(MAXI), .ITER_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_init(a_init), .b_init(b_init), .c_init(c_init), .d_init(d_init),
        .busy(busy), .done(done),
        .a_res(a_res), .b_res(b_res), .c_res(c_res), .d_res(d_res),
        .z_res(z_res), .iter_count(iter_count), .sat_flag(sat_flag), .ovf_flag(ovf_flag),
        .start_func(start_func), .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out),
        .z_in(z_in), .func_done(func_done), .func_ovf(func_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] r [4];
        logic [31:0] z;
        int          iter;
        bit          sat;
        bit          ovf;
        int          nreq;
    } exp_t;

    exp_t exp_q[$];
    exp_t me;
    int   checks = 0, errors = 0;
    int   kc [4];
    int   cc = 0;
    int   ovf_at = 0;
    int   lat_fix = 0;
    int   n_req = 0;
    int   done_cnt = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", n, act, ex);
        end
    endtask

    function automatic longint fz(int p0, int p1, int p2, int p3);
        return longint'(kc[0]) * p0 + longint'(kc[1]) * p1 + longint'(kc[2]) * p2 + longint'(kc[3]) * p3 + cc;
    endfunction

    // Whole-run reference: walks the iterations with plain integer arithmetic
    function automatic exp_t ref_run(int i0, int i1, int i2, int i3);
        exp_t   e;
        int     x [4];
        int     p [4];
        longint z0, zi, nv;
        longint st [4];
        int     n;
        bit     moved;
        x = '{i0, i1, i2, i3};
        e.sat = 0;
        e.ovf = 0;
        e.iter = 0;
        n = 0;
        for (int it = 1; it <= MAXI; it++) begin
            z0 = fz(x[0], x[1], x[2], x[3]);
            n++;
            e.ovf |= (n == ovf_at);
            moved = 0;
            for (int i = 0; i < 4; i++) begin
                p = x;
                p[i] = x[i] + DL;
                if (p[i] > 32767) begin p[i] = 32767; e.sat = 1; end
                zi = fz(p[0], p[1], p[2], p[3]);
                n++;
                e.ovf |= (n == ovf_at);
                st[i] = (zi - z0) >>> SH;
                moved |= (st[i] != 0);
            end
            e.iter = it;
            if (!moved) begin
                for (int i = 0; i < 4; i++) e.r[i] = 16'(x[i]);
                e.z = 32'(z0);
                e.nreq = n;
                return e;
            end
            for (int i = 0; i < 4; i++) begin
                nv = x[i] - st[i];
                if (nv > 32767) begin nv = 32767; e.sat = 1; end
                else if (nv < -32768) begin nv = -32768; e.sat = 1; end
                x[i] = int'(nv);
            end
        end
        z0 = fz(x[0], x[1], x[2], x[3]);
        n++;
        e.ovf |= (n == ovf_at);
        for (int i = 0; i < 4; i++) e.r[i] = 16'(x[i]);
        e.z = 32'(z0);
        e.nreq = n;
        return e;
    endfunction

    // Func unit model: level func_done after a per-request latency, plus handshake checks
    bit          sf_prev = 0, pending = 0;
    int          left = 0;
    logic [63:0] snap = 0;
    always @(negedge clk) begin
        if (rst) begin
            func_done = 0;
            func_ovf  = 0;
            pending   = 0;
            sf_prev   = 0;
        end else begin
            if (start_func && sf_prev) begin
                checks++;
                if ({a_out, b_out, c_out, d_out} !== snap) begin
                    errors++;
                    $display("FAIL operand_stable actual=%h required=%h", {a_out, b_out, c_out, d_out}, snap);
                end
            end
            if (start_func && !sf_prev) begin
                chk("no_rise_while_done", 32'(func_done), 0);
                snap    = {a_out, b_out, c_out, d_out};
                pending = 1;
                left    = lat_fix > 0 ? lat_fix : $urandom_range(1, 10);
                n_req++;
            end
            if (pending && start_func) begin
                left--;
                if (left == 0) begin
                    pending   = 0;
                    z_in      = 32'(fz(int'($signed(snap[63:48])), int'($signed(snap[47:32])),
                                       int'($signed(snap[31:16])), int'($signed(snap[15:0]))));
                    func_ovf  = (n_req == ovf_at);
                    func_done = 1;
                end
            end
            if (!start_func && func_done) begin
                func_done = 0;
                func_ovf  = 0;
            end
            sf_prev = start_func;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                me = exp_q.pop_front();
                chk("a_res", a_res, me.r[0]);
                chk("b_res", b_res, me.r[1]);
                chk("c_res", c_res, me.r[2]);
                chk("d_res", d_res, me.r[3]);
                chk("z_res", z_res, me.z);
                chk("iter_count", iter_count, 32'(me.iter));
                chk("sat_flag", sat_flag, me.sat);
                chk("ovf_flag", ovf_flag, me.ovf);
                chk("busy_at_done", busy, 0);
                chk("requests", 32'(n_req), 32'(me.nreq));
            end
        end
    end

    task automatic check_zero(input string n);
        chk({n, "_ctl"}, {27'd0, busy, done, start_func, sat_flag, ovf_flag}, 0);
        chk({n, "_ops"}, 32'(|{a_out, b_out, c_out, d_out}), 0);
        chk({n, "_res"}, 32'(|{a_res, b_res, c_res, d_res, z_res, iter_count}), 0);
    endtask

    task automatic run(input int i0, input int i1, input int i2, input int i3, input int ovf);
        int d0;
        ovf_at = ovf;
        exp_q.push_back(ref_run(i0, i1, i2, i3));
        @(negedge clk);
        n_req  = 0;
        a_init = 16'(i0);
        b_init = 16'(i1);
        c_init = 16'(i2);
        d_init = 16'(i3);
        start  = 1;
        d0     = done_cnt;
        @(negedge clk);
        start = 0;
        chk("busy_rise", 32'(busy), 1);
        repeat ($urandom_range(2, 20)) @(negedge clk);
        if (done_cnt == d0) begin
            start  = 1;
            a_init = 16'($urandom);
            @(negedge clk);
            start = 0;
        end
        for (int t = 0; t < 3000 && done_cnt == d0; t++) @(negedge clk);
        if (done_cnt == d0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=0 required=1");
            void'(exp_q.pop_front());
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    initial begin
        kc = '{0, 0, 0, 0};
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 0;
        @(negedge clk);
        check_zero("idle");

        kc = '{1, 0, 0, 0}; cc = 0;
        run(256, 0, 0, 0, 0);
        kc = '{0, 0, 0, 0}; cc = 'h500;
        run(rnd16(), rnd16(), rnd16(), rnd16(), 0);
        kc = '{-1, 0, 0, 0}; cc = 0;
        run(32766, 0, 0, 0, 0);
        kc = '{2, -1, 0, 3}; cc = 17;
        run(rnd16(), rnd16(), rnd16(), rnd16(), 3);
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 4; i++) kc[i] = int'($urandom_range(0, 6)) - 3;
            cc = int'($urandom_range(0, 4000)) - 2000;
            run(rnd16(), rnd16(), rnd16(), rnd16(), int'($urandom_range(0, 16)));
        end

        // Reset in the middle of a long request
        kc = '{1, 0, 0, 0}; cc = 0; lat_fix = 10; ovf_at = 0;
        @(negedge clk);
        a_init = 16'h0100; b_init = 0; c_init = 0; d_init = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        for (int t = 0; t < 50 && !start_func; t++) @(negedge clk);
        chk("mid_req_start_func", 32'(start_func), 1);
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        check_zero("mid_reset");
        rst = 0;
        lat_fix = 0;
        @(negedge clk);
        chk("no_done_after_reset", 32'(done), 0);
        run(256, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
